inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 123 ++++++++++++
 tb/tb_inst_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues single outstanding program-memory reads and
// holds one instruction for the decoder, with branch redirect and request draining.
module inst_fetch #(
  parameter logic [12:0] RESET_VECTOR = 13'h0000,
  parameter logic [7:0]  NOP_INST     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pm_req,
  output logic [12:0] pm_addr,
  input  logic        pm_ack,
  input  logic [7:0]  pm_data,
  input  logic        stall,
  input  logic        branch,
  input  logic [12:0] branch_target,
  output logic [7:0]  inst_reg,
  output logic        inst_valid,
  output logic [12:0] counter
);

  typedef enum logic [1:0] {IDLE, WAIT, FULL, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [12:0] fetch_pc_q, fetch_pc_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [12:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = WAIT;
      WAIT: begin
        if (branch && !pm_ack) state_d = DRAIN;
        else if (branch)       state_d = WAIT;
        else if (pm_ack)       state_d = FULL;
      end
      FULL:  if (branch || !stall) state_d = WAIT;
      DRAIN: if (pm_ack) state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  // addr_q is the request address; it only moves when no request is outstanding,
  // so a branch during WAIT/DRAIN lands in fetch_pc and is picked up after the ack.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        if (branch) begin
          fetch_pc_d = branch_target;
          addr_d     = branch_target;
        end else begin
          addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (branch) begin
          fetch_pc_d = branch_target;
          if (pm_ack) addr_d = branch_target;
        end else if (pm_ack) begin
          inst_d     = pm_data;
          cnt_d      = addr_q;
          valid_d    = 1'b1;
          fetch_pc_d = addr_q + 13'd1;
          addr_d     = addr_q + 13'd1;
        end
      end
      FULL: begin
        if (branch) begin
          fetch_pc_d = branch_target;
          addr_d     = branch_target;
          valid_d    = 1'b0;
          inst_d     = NOP_INST;
        end else if (!stall) begin
          addr_d  = fetch_pc_q;
          valid_d = 1'b0;
          inst_d  = NOP_INST;
        end
      end
      DRAIN: begin
        if (branch) fetch_pc_d = branch_target;
        if (pm_ack) addr_d = branch ? branch_target : fetch_pc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_VECTOR;
      addr_q     <= RESET_VECTOR;
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
      cnt_q      <= RESET_VECTOR;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pm_req     = (state_q == WAIT) || (state_q == DRAIN);
  assign pm_addr    = addr_q;
  assign inst_reg   = inst_q;
  assign inst_valid = valid_q;
  assign counter    = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then randomized traffic, all checked
// against a transaction-level model of the fetch unit.
module tb_inst_fetch;
  localparam logic [12:0] RV  = 13'h0000;
  localparam logic [7:0]  NOP = 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic        pm_req;
  logic [12:0] pm_addr;
  logic        pm_ack;
  logic [7:0]  pm_data;
  logic        stall;
  logic        branch;
  logic [12:0] branch_target;
  logic [7:0]  inst_reg;
  logic        inst_valid;
  logic [12:0] counter;

  inst_fetch #(.RESET_VECTOR(RV), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .pm_req(pm_req), .pm_addr(pm_addr),
    .pm_ack(pm_ack), .pm_data(pm_data), .stall(stall), .branch(branch),
    .branch_target(branch_target), .inst_reg(inst_reg),
    .inst_valid(inst_valid), .counter(counter)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: either starting up, waiting for an outstanding read (possibly one to
  // be thrown away), or holding an instruction.
  bit          m_start, m_req, m_valid, m_kill;
  logic [12:0] m_pc, m_addr, m_cnt;
  logic [7:0]  m_inst;

  task automatic model_reset();
    m_start = 1; m_req = 0; m_valid = 0; m_kill = 0;
    m_pc = RV; m_addr = RV; m_cnt = RV; m_inst = NOP;
  endtask

  task automatic model_edge();
    if (m_start) begin
      m_start = 0;
      if (branch) m_pc = branch_target;
      m_req = 1; m_addr = m_pc; m_kill = 0;
    end else if (m_req) begin
      if (pm_ack) begin
        if (branch) begin
          m_pc = branch_target; m_addr = branch_target; m_kill = 0;
        end else if (m_kill) begin
          m_addr = m_pc; m_kill = 0;
        end else begin
          m_valid = 1; m_inst = pm_data; m_cnt = m_addr;
          m_pc = m_addr + 13'd1; m_req = 0;
        end
      end else if (branch) begin
        m_pc = branch_target; m_kill = 1;
      end
    end else if (m_valid) begin
      if (branch) begin
        m_valid = 0; m_inst = NOP; m_pc = branch_target;
        m_req = 1; m_addr = branch_target;
      end else if (!stall) begin
        m_valid = 0; m_inst = NOP; m_req = 1; m_addr = m_pc;
      end
    end
  endtask

  task automatic check_all();
    chk("pm_req", 32'(pm_req), 32'(m_req));
    if (m_req) chk("pm_addr", 32'(pm_addr), 32'(m_addr));
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("inst_reg", 32'(inst_reg), 32'(m_inst));
    chk("counter", 32'(counter), 32'(m_cnt));
  endtask

  task automatic step(input bit br, input logic [12:0] tg, input bit st,
                      input bit ak, input logic [7:0] dat);
    branch = br; branch_target = tg; stall = st; pm_ack = ak; pm_data = dat;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int dly;

  initial begin
    reset = 1'b0; pm_ack = 0; pm_data = 0; stall = 0; branch = 0; branch_target = 0;
    model_reset();
    #1;
    chk("rst_pm_req", 32'(pm_req), 0);
    chk("rst_pm_addr", 32'(pm_addr), 32'(RV));
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst", 32'(inst_reg), 32'(NOP));
    chk("rst_counter", 32'(counter), 32'(RV));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 chk("rel_no_req", 32'(pm_req), 0);
    step(0, 0, 0, 0, 0);
    chk("first_req_addr", 32'({pm_req, pm_addr}), 32'({1'b1, RV}));

    // sequential fetch, single-cycle ack, no stall
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1, 8'(8'h30 + k));
      chk("seq_inst", 32'(inst_reg), 32'(8'h30 + k));
      chk("seq_cnt", 32'(counter), k);
      step(0, 0, 0, 0, 0);
      chk("seq_next_addr", 32'(pm_addr), k + 1);
    end

    // stall holds 8'h1D at counter 5
    step(0, 0, 0, 1, 8'h1D);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0, 0);
      chk("stall_hold", 32'({pm_req, inst_valid, inst_reg, counter}),
          32'({1'b0, 1'b1, 8'h1D, 13'd5}));
    end
    step(0, 0, 0, 0, 0);
    chk("after_stall_addr", 32'({pm_req, pm_addr}), 32'({1'b1, 13'd6}));

    // branch and ack together: data dropped, redirect to 3
    step(1, 13'd3, 0, 1, 8'hEE);
    chk("br_ack_novalid", 32'(inst_valid), 0);
    chk("br_ack_addr", 32'(pm_addr), 3);

    // branch during outstanding read at 3, ack two cycles later
    step(1, 13'h0100, 0, 0, 0);
    chk("drain_addr_hold", 32'({pm_req, pm_addr}), 32'({1'b1, 13'd3}));
    step(0, 0, 0, 0, 0);
    chk("drain_addr_hold2", 32'({pm_req, pm_addr, inst_valid}), 32'({1'b1, 13'd3, 1'b0}));
    step(0, 0, 0, 1, 8'hAA);
    chk("drain_discard", 32'(inst_valid), 0);
    chk("drain_next_addr", 32'(pm_addr), 32'h0100);

    // wrap from 1FFF
    step(1, 13'h1FFF, 0, 1, 8'h11);
    step(0, 0, 0, 1, 8'h5A);
    chk("wrap_cnt", 32'(counter), 32'h1FFF);
    step(0, 0, 0, 0, 0);
    chk("wrap_addr", 32'(pm_addr), 0);

    // reset while draining
    step(1, 13'h0055, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_drain_req", 32'(pm_req), 0);
    chk("rst_drain_valid", 32'(inst_valid), 0);
    chk("rst_drain_addr", 32'(pm_addr), 32'(RV));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("rst_drain_first", 32'({pm_req, pm_addr}), 32'({1'b1, RV}));

    // randomized traffic
    dly = 0;
    for (int i = 0; i < 3000; i++) begin
      bit br, st, ak;
      logic [12:0] tg;
      br = ($urandom_range(0, 7) == 0);
      tg = ($urandom_range(0, 3) == 0) ? 13'h1FFF : 13'($urandom);
      st = ($urandom_range(0, 2) == 0);
      if (pm_req) begin
        if (dly == 0) begin
          ak = 1; dly = $urandom_range(0, 2);
        end else begin
          ak = 0; dly--;
        end
      end else begin
        ak = ($urandom_range(0, 7) == 0);
      end
      step(br, tg, st, ak, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
